// File: rtl/alu_op_sequencer_if.sv
// Command, response and ALU-side signals between the sequencer and its environment.
// The sequencer connects through the slave modport; the command source, response sink and ALU use master.
interface alu_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [REG_AW-1:0] cmd_dst;
    logic [REG_AW-1:0] cmd_src_a;
    logic [REG_AW-1:0] cmd_src_b;
    logic [DATA_W-1:0] cmd_imm;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [1:0]        alu_sel;
    logic [DATA_W-1:0] alu_result;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        output alu_result, rsp_ready,
        input  cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_err, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src_a, cmd_src_b, cmd_imm,
        input  alu_result, rsp_ready,
        output cmd_ready, alu_a, alu_b, alu_sel, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Command sequencer for an external combinational ALU: small operand register file,
// one-cycle ALU settle, write-back and response handshake, with a divide-by-zero guard.
module alu_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2
) (
    input  logic              clk,
    input  logic              rst,
    alu_op_sequencer_if.slave bus
);
    localparam int         NREGS   = 2 ** REG_AW;
    localparam logic [2:0] OP_DIV  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] regs_q [NREGS];
    logic [REG_AW-1:0] dst_q;
    logic [DATA_W-1:0] alu_a_q;
    logic [DATA_W-1:0] alu_b_q;
    logic [1:0]        alu_sel_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic              rsp_err_q;

    logic              accept;
    logic              div_zero;
    logic [DATA_W-1:0] opa_d;
    logic [DATA_W-1:0] opb_d;
    logic              wr_en_d;
    logic [REG_AW-1:0] wr_addr_d;
    logic [DATA_W-1:0] wr_data_d;

    assign bus.cmd_ready = (state_q == IDLE) && !rst;
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign opa_d         = regs_q[bus.cmd_src_a];
    assign opb_d         = regs_q[bus.cmd_src_b];
    assign div_zero      = (bus.cmd_op == OP_DIV) && (opb_d == '0);

    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_sel   = alu_sel_q;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.busy      = (state_q != IDLE);

    // Single write port shared by LOAD (at acceptance) and ALU write-back (leaving EXEC).
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = dst_q;
        wr_data_d = bus.alu_result;
        if (state_q == EXEC) begin
            wr_en_d = 1'b1;
        end else if (accept && bus.cmd_op == OP_LOAD) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.cmd_dst;
            wr_data_d = bus.cmd_imm;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_d) begin
            regs_q[wr_addr_d] <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            dst_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_sel_q  <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        dst_q <= bus.cmd_dst;
                        if (!bus.cmd_op[2]) begin
                            if (div_zero) begin
                                rsp_data_q <= {DATA_W{1'b1}};
                                rsp_err_q  <= 1'b1;
                                state_q    <= RESP;
                            end else begin
                                alu_a_q   <= opa_d;
                                alu_b_q   <= opb_d;
                                alu_sel_q <= bus.cmd_op[1:0];
                                state_q   <= EXEC;
                            end
                        end else if (bus.cmd_op == OP_LOAD) begin
                            rsp_data_q <= bus.cmd_imm;
                            rsp_err_q  <= 1'b0;
                            state_q    <= RESP;
                        end else begin
                            rsp_data_q <= '0;
                            rsp_err_q  <= 1'b1;
                            state_q    <= RESP;
                        end
                    end
                end
                EXEC: begin
                    rsp_data_q <= bus.alu_result;
                    rsp_err_q  <= 1'b0;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
module tb_alu_op_sequencer;
    localparam int DATA_W = 8;
    localparam int REG_AW = 2;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] exec_a;
    logic [7:0] exec_b;
    logic [1:0] exec_sel;

    always #5 clk = ~clk;

    alu_op_sequencer_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) bus ();

    alu_op_sequencer #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        case (bus.alu_sel)
            2'b00:   bus.alu_result = bus.alu_a + bus.alu_b;
            2'b01:   bus.alu_result = bus.alu_a - bus.alu_b;
            2'b10:   bus.alu_result = bus.alu_a * bus.alu_b;
            default: bus.alu_result = (bus.alu_b == 8'd0) ? 8'hFF : bus.alu_a / bus.alu_b;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns just after the acceptance edge.
    task automatic send(input logic [2:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input logic [7:0] imm);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_dst   = dst;
        bus.cmd_src_a = sa;
        bus.cmd_src_b = sb;
        bus.cmd_imm   = imm;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [7:0] exp_data, input logic exp_err,
                            input int exp_lat);
        int n = 1;
        @(negedge clk);
        if (!bus.rsp_valid) begin
            exec_a   = bus.alu_a;
            exec_b   = bus.alu_b;
            exec_sel = bus.alu_sel;
        end
        while (!bus.rsp_valid && n < 16) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, bus.rsp_valid, 1);
        chk({tag, "_latency"}, n, exp_lat);
        chk({tag, "_data"}, bus.rsp_data, exp_data);
        chk({tag, "_err"}, bus.rsp_err, exp_err);
        $display("[TB] %s: data=%0d err=%0d latency=%0d", tag, bus.rsp_data, bus.rsp_err, n);
    endtask

    task automatic idle_after(input string tag);
        @(negedge clk);
        chk({tag, "_rsp_valid_drop"}, bus.rsp_valid, 0);
        chk({tag, "_busy_drop"}, bus.busy, 0);
        chk({tag, "_cmd_ready_back"}, bus.cmd_ready, 1);
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] sa, input logic [1:0] sb, input logic [7:0] imm,
                       input logic [7:0] exp_data, input logic exp_err, input int exp_lat);
        send(op, dst, sa, sb, imm);
        wait_rsp(tag, exp_data, exp_err, exp_lat);
        idle_after(tag);
    endtask

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_dst   = '0;
        bus.cmd_src_a = '0;
        bus.cmd_src_b = '0;
        bus.cmd_imm   = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_alu_a", bus.alu_a, 0);
        chk("rst_alu_b", bus.alu_b, 0);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_rsp_data", bus.rsp_data, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        rst = 1'b0;
        @(negedge clk);

        run("load_r0_200", 3'd4, 2'd0, 2'd0, 2'd0, 8'd200, 8'd200, 1'b0, 1);
        run("load_r1_100", 3'd4, 2'd1, 2'd0, 2'd0, 8'd100, 8'd100, 1'b0, 1);

        send(3'd0, 2'd2, 2'd0, 2'd1, 8'd0);
        wait_rsp("add_r2", 8'd44, 1'b0, 2);
        chk("add_exec_a", exec_a, 200);
        chk("add_exec_b", exec_b, 100);
        chk("add_exec_sel", exec_sel, 0);
        idle_after("add_r2");

        run("sub_r3", 3'd1, 2'd3, 2'd1, 2'd0, 8'd0, 8'd156, 1'b0, 2);
        chk("sub_alu_sel_held", bus.alu_sel, 1);

        run("load_r0_20", 3'd4, 2'd0, 2'd0, 2'd0, 8'd20, 8'd20, 1'b0, 1);
        run("load_r1_13", 3'd4, 2'd1, 2'd0, 2'd0, 8'd13, 8'd13, 1'b0, 1);
        run("mul_r2", 3'd2, 2'd2, 2'd0, 2'd1, 8'd0, 8'd4, 1'b0, 2);
        chk("mul_alu_sel_held", bus.alu_sel, 2);

        run("load_r0_200b", 3'd4, 2'd0, 2'd0, 2'd0, 8'd200, 8'd200, 1'b0, 1);
        run("load_r1_7", 3'd4, 2'd1, 2'd0, 2'd0, 8'd7, 8'd7, 1'b0, 1);
        run("div_r3", 3'd3, 2'd3, 2'd0, 2'd1, 8'd0, 8'd28, 1'b0, 2);
        chk("div_alu_sel_held", bus.alu_sel, 3);
        chk("div_alu_b_held", bus.alu_b, 7);

        run("load_r2_44", 3'd4, 2'd2, 2'd0, 2'd0, 8'd44, 8'd44, 1'b0, 1);
        run("load_r1_0", 3'd4, 2'd1, 2'd0, 2'd0, 8'd0, 8'd0, 1'b0, 1);
        run("div_by_zero", 3'd3, 2'd2, 2'd0, 2'd1, 8'd0, 8'hFF, 1'b1, 1);
        chk("dbz_alu_b_not_issued", bus.alu_b, 7);
        run("r2_kept_44", 3'd0, 2'd3, 2'd2, 2'd1, 8'd0, 8'd44, 1'b0, 2);
        run("reserved_op6", 3'd6, 2'd0, 2'd0, 2'd0, 8'd55, 8'd0, 1'b1, 1);

        // Backpressure, with a stray LOAD r3=99 offered while the response is stalled.
        bus.rsp_ready = 1'b0;
        send(3'd0, 2'd2, 2'd0, 2'd0, 8'd0);
        wait_rsp("add_backpressure", 8'd144, 1'b0, 2);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'd4;
        bus.cmd_dst   = 2'd3;
        bus.cmd_imm   = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_data", bus.rsp_data, 144);
            chk("bp_rsp_err", bus.rsp_err, 0);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
            chk("bp_busy", bus.busy, 1);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        idle_after("bp_release");
        run("r3_not_overwritten", 3'd0, 2'd1, 2'd3, 2'd1, 8'd0, 8'd44, 1'b0, 2);

        // Reset while the ADD into r2 sits in EXEC.
        send(3'd0, 2'd2, 2'd0, 2'd1, 8'd0);
        @(negedge clk);
        chk("abort_in_exec_busy", bus.busy, 1);
        chk("abort_in_exec_valid", bus.rsp_valid, 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_rsp_valid", bus.rsp_valid, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_cmd_ready_in_rst", bus.cmd_ready, 0);
        chk("abort_alu_a", bus.alu_a, 0);
        chk("abort_alu_b", bus.alu_b, 0);
        chk("abort_alu_sel", bus.alu_sel, 0);
        chk("abort_rsp_data", bus.rsp_data, 0);
        chk("abort_rsp_err", bus.rsp_err, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_response", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b1;
        send(3'd0, 2'd2, 2'd0, 2'd1, 8'd0);
        wait_rsp("post_rst_add_r2", 8'd0, 1'b0, 2);
        chk("post_rst_exec_a", exec_a, 0);
        chk("post_rst_exec_b", exec_b, 0);
        idle_after("post_rst_add_r2");
        run("post_rst_r3_r1", 3'd0, 2'd0, 2'd3, 2'd1, 8'd0, 8'd0, 1'b0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-driven initiator for the 8-bit combinational ALU (2-bit select: 00 add, 01 sub, 10 mul, 11 div).
- Holds a small operand register file and accepts load/compute commands on a valid/ready handshake.
- Drives ALU operands and select, captures the ALU result, writes it back, and returns a response on a second valid/ready handshake.
- Guards division by zero so the ALU is never issued B=0 with select 11.

Parameters:
- DATA_W, 8, operand/result width; must match the ALU width.
- REG_AW, 2, register-file address width; the file holds 2**REG_AW entries.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  0-3 = ALU op (value drives ALU select); 4 = LOAD immediate; 5-7 reserved.
- cmd_dst  in  REG_AW  destination register.
- cmd_src_a  in  REG_AW  operand A register.
- cmd_src_b  in  REG_AW  operand B register.
- cmd_imm  in  DATA_W  immediate for LOAD.
- alu_a  out  DATA_W  ALU operand A, registered.
- alu_b  out  DATA_W  ALU operand B, registered.
- alu_sel  out  2  ALU select, registered.
- alu_result  in  DATA_W  ALU combinational output.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_data  out  DATA_W  value written (or error code).
- rsp_err  out  1  command failed.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (sync, rst=1 at an edge):
  - All registers, alu_a, alu_b, alu_sel, rsp_data and rsp_err go to 0; rsp_valid goes to 0; state goes to IDLE.
  - cmd_ready is 0 while rst is high.
- States: IDLE, EXEC, RESP.
- cmd_ready = (state==IDLE) and not rst. A command is accepted on an edge where cmd_valid and cmd_ready are both 1.
- Operand read: regfile is read at the acceptance edge. src_a, src_b and dst may alias freely.
- IDLE, on accept:
  - op 0-3 with a legal operand: alu_a <= reg[src_a], alu_b <= reg[src_b], alu_sel <= op[1:0]; go to EXEC.
  - op 3 with reg[src_b]==0: no ALU issue; rsp_data <= 8'hFF, rsp_err <= 1; register file unchanged; go to RESP.
  - op 4 (LOAD): reg[dst] <= cmd_imm, rsp_data <= cmd_imm, rsp_err <= 0; go to RESP.
  - op 5-7: rsp_data <= 0, rsp_err <= 1; no write; go to RESP.
- EXEC: one cycle for the ALU to settle. At the edge leaving EXEC: reg[dst] <= alu_result, rsp_data <= alu_result, rsp_err <= 0; go to RESP.
- RESP:
  - rsp_valid=1; rsp_data and rsp_err are held stable until an edge where rsp_ready=1.
  - On that edge go to IDLE with rsp_valid=0.
  - No new command is accepted in the RESP cycle, even if rsp_ready is high; cmd_ready rises the cycle after.
- Latency, counted from the acceptance edge E0 with rsp_ready held high:
  - ALU ops: rsp_valid is high after E0+1. Accept-to-accept minimum is 3 cycles.
  - LOAD, divide-by-zero and reserved ops: rsp_valid is high after E0. Minimum is 2 cycles.
- Arithmetic (performed by the ALU; the sequencer takes the low DATA_W bits as returned):
  - add and sub wrap modulo 2**DATA_W.
  - mul keeps the low DATA_W bits.
  - div returns the unsigned integer quotient.
- ALU outputs alu_a, alu_b and alu_sel hold their last values outside EXEC.
- Reset mid-EXEC or mid-RESP aborts the command: no write-back, no response, all outputs return to reset values.
- cmd_* inputs are ignored when cmd_ready=0.

Test Plan:
- Reset, then LOAD r0=200, LOAD r1=100 -> each response: rsp_data=200 / 100, rsp_err=0, rsp_valid one cycle after accept.
- ADD r2=r0+r1 -> alu_a=200, alu_b=100, alu_sel=00 during EXEC; rsp_data=44; r2=44. SUB r3=r1-r0 -> rsp_data=156.
- LOAD r0=20, r1=13; MUL r2 -> rsp_data=4 (260 mod 256). LOAD r0=200, r1=7; DIV r3 -> rsp_data=28.
- LOAD r1=0; DIV r2=r0/r1 with r2 previously 44 -> rsp_err=1, rsp_data=FF, r2 still 44, no EXEC cycle. op=6 -> rsp_err=1, rsp_data=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after ADD -> rsp_valid, rsp_data and rsp_err stable, cmd_ready=0, busy=1; release -> IDLE next cycle.
- Assert rst during EXEC of ADD into r2 -> no response; after reset all registers read 0; a following ADD r2=r0+r1 returns 0.
